fact_accel_ctrl: RTL

Memory-mapped factorial accelerator controller for the SoC, attached to the processor data bus next to data memory and the GPIO block. Software writes an operand, writes GO, polls STATUS, then reads RESULT. Internally a three-state FSM sequences a down-counter and a 32-bit product register, doing one multiply per cycle. It rejects operands whose factorial does not fit in 32 bits.

---
 rtl/fact_accel_ctrl_if.sv | 25 ++
 rtl/fact_accel_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fact_accel_ctrl_if.sv
// Bus-side signal bundle for the factorial accelerator: register write port,
// combinational read data and the result-valid flag.
interface fact_accel_ctrl_if;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        done;

    modport master (
        output we,
        output a,
        output wd,
        input  rd,
        input  done
    );

    modport slave (
        input  we,
        input  a,
        input  wd,
        output rd,
        output done
    );
endinterface

// File: rtl/fact_accel_ctrl.sv
// Memory-mapped factorial accelerator. Software writes N, writes GO, polls
// STATUS and reads RESULT. One multiply per BUSY cycle; operands above NMAX
// are rejected immediately with err set and RESULT cleared.
module fact_accel_ctrl #(
    parameter int NMAX = 12
) (
    input  logic             clk,
    input  logic             rst,
    fact_accel_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] NMAX_L = 4'(NMAX);

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_GO     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    logic [1:0]  state_r;
    logic [3:0]  n_r;
    logic [3:0]  cnt_r;
    logic [31:0] prod_r;
    logic [31:0] result_r;
    logic        done_r;
    logic        err_r;

    logic        busy_s;
    logic        wr_n_s;
    logic        start_s;
    logic [31:0] rd_s;

    // Decode bus writes; both N updates and starts are locked out while BUSY.
    always_comb begin
        busy_s  = 1'b0;
        wr_n_s  = 1'b0;
        start_s = 1'b0;
        if (state_r == ST_BUSY) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if (bus.we && !busy_s && (bus.a == A_N)) begin
            wr_n_s = 1'b1;
        end else begin
            wr_n_s = 1'b0;
        end
        if (bus.we && !busy_s && (bus.a == A_GO) && bus.wd[0]) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Operand register, sequencing FSM, down-counter, product and result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            n_r      <= 4'd0;
            cnt_r    <= 4'd0;
            prod_r   <= 32'd1;
            result_r <= 32'd0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (wr_n_s) begin
                n_r <= bus.wd[3:0];
            end
            case (state_r)
                ST_BUSY: begin
                    if (cnt_r > 4'd1) begin
                        // Truncation to 32 bits never bites for legal operands.
                        prod_r <= prod_r * {28'd0, cnt_r};
                        cnt_r  <= cnt_r - 4'd1;
                    end else begin
                        // RESULT only ever sees the finished product.
                        result_r <= prod_r;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        if (n_r > NMAX_L) begin
                            result_r <= 32'd0;
                            err_r    <= 1'b1;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            cnt_r   <= n_r;
                            prod_r  <= 32'd1;
                            done_r  <= 1'b0;
                            err_r   <= 1'b0;
                            state_r <= ST_BUSY;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Side-effect-free read mux; unused bits read as zero.
    always_comb begin
        rd_s = 32'd0;
        case (bus.a)
            A_N:      rd_s = {28'd0, n_r};
            A_GO:     rd_s = {31'd0, busy_s};
            A_STATUS: rd_s = {29'd0, busy_s, err_r, done_r};
            A_RESULT: rd_s = result_r;
            default:  rd_s = 32'd0;
        endcase
    end

    assign bus.rd   = rd_s;
    assign bus.done = done_r;

endmodule
